// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding-select encoding and the register number of the PC.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [3:0] REG_PC = 4'hF;

    // Memory stage beats Writeback; the PC is never a forwarding target.
    function automatic fwd_sel_e fwd_select(
        input logic [3:0] ra,
        input logic       reg_write_m,
        input logic [3:0] wa3_m,
        input logic       reg_write_w,
        input logic [3:0] wa3_w
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ra != REG_PC) begin
            if (reg_write_m && (wa3_m == ra)) begin
                sel = FWD_MEM;
            end else if (reg_write_w && (wa3_w == ra)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
// Clear beats increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = &r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage ARM pipeline: Execute operand forwarding,
// load-use stalls, PC-write / branch flushes, and stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             clr_cnt,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic r_pcw_e;
    logic r_pcw_m;
    logic r_pcw_w;
    logic w_ldstall;
    logic w_pcwr_pend;
    logic w_flush_e;

    assign ForwardAE = fwd_select(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardBE = fwd_select(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    assign w_ldstall   = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    assign w_pcwr_pend = PCSrcD | r_pcw_e | r_pcw_m;
    assign w_flush_e   = w_ldstall | BranchTakenE;

    assign StallF = w_ldstall | w_pcwr_pend;
    assign StallD = w_ldstall;
    assign FlushD = w_pcwr_pend | r_pcw_w | BranchTakenE;
    assign FlushE = w_flush_e;

    // Never stalled: a held Decode slot is bubbled into Execute by FlushE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcw_e <= 1'b0;
            r_pcw_m <= 1'b0;
            r_pcw_w <= 1'b0;
        end else begin
            r_pcw_e <= PCSrcD & ~w_flush_e;
            r_pcw_m <= r_pcw_e;
            r_pcw_w <= r_pcw_m;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (w_ldstall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (w_flush_e),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued when inputs are driven
// and popped/compared when outputs settle; a 3-bit-counter instance covers saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic        PCSrcD, BranchTakenE, clr_cnt;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_fae, s_fbe;
    logic        s_sf, s_sd, s_fd, s_fe;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
        .clr_cnt(clr_cnt),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
        .clr_cnt(clr_cnt),
        .ForwardAE(s_fae), .ForwardBE(s_fbe),
        .StallF(s_sf), .StallD(s_sd), .FlushD(s_fd), .FlushE(s_fe),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [2:0]  scs;
        logic [2:0]  fcs;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, written from the behavioural description.
    logic m_pe, m_pm, m_pw;
    int   m_sc, m_fc, m_scs, m_fcs;

    logic        obs_sf, obs_fd;
    logic [15:0] obs_sc, obs_fc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
        if (ra == 4'd15)                   return 2'b00;
        if (RegWriteM && WA3M == ra)       return 2'b10;
        if (RegWriteW && WA3W == ra)       return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_ldstall();
        return MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
    endfunction

    task automatic model_reset();
        m_pe = 0; m_pm = 0; m_pw = 0;
        m_sc = 0; m_fc = 0; m_scs = 0; m_fcs = 0;
    endtask

    task automatic zero_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
        WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; BranchTakenE = 0; clr_cnt = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic cycle(input string tag);
        exp_t e, g;
        logic ld, fe, pend;
        ld   = ref_ldstall();
        fe   = ld || BranchTakenE;
        pend = PCSrcD || m_pe || m_pm;
        e.fa  = ref_fwd(RA1E);
        e.fb  = ref_fwd(RA2E);
        e.sf  = ld || pend;
        e.sd  = ld;
        e.fd  = pend || m_pw || BranchTakenE;
        e.fe  = fe;
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        e.scs = 3'(m_scs);
        e.fcs = 3'(m_fcs);
        exp_q.push_back(e);
        #1;
        g = exp_q.pop_front();
        chk({tag, ".FAE"}, 32'(ForwardAE), 32'(g.fa));
        chk({tag, ".FBE"}, 32'(ForwardBE), 32'(g.fb));
        chk({tag, ".StallF"}, 32'(StallF), 32'(g.sf));
        chk({tag, ".StallD"}, 32'(StallD), 32'(g.sd));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(g.fd));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(g.fe));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(g.sc));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(g.fc));
        chk({tag, ".s_stall_cnt"}, 32'(s_stall_cnt), 32'(g.scs));
        chk({tag, ".s_flush_cnt"}, 32'(s_flush_cnt), 32'(g.fcs));
        obs_sf = StallF; obs_fd = FlushD; obs_sc = stall_cnt; obs_fc = flush_cnt;
        $display("[%0t] %s FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b sc=%0d fc=%0d",
                 $time, tag, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
                 stall_cnt, flush_cnt);
        @(posedge clk);
        if (reset) begin
            if (clr_cnt) begin
                m_sc = 0; m_fc = 0; m_scs = 0; m_fcs = 0;
            end else begin
                if (ld && m_sc < 65535) m_sc++;
                if (fe && m_fc < 65535) m_fc++;
                if (ld && m_scs < 7)    m_scs++;
                if (fe && m_fcs < 7)    m_fcs++;
            end
            m_pw = m_pm;
            m_pm = m_pe;
            m_pe = PCSrcD && !fe;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_sf, n_fd;
        reset = 1'b0;
        zero_inputs();
        model_reset();
        #3;
        chk("rst.FAE", 32'(ForwardAE), 0);
        chk("rst.FBE", 32'(ForwardBE), 0);
        chk("rst.StallF", 32'(StallF), 0);
        chk("rst.FlushD", 32'(FlushD), 0);
        chk("rst.FlushE", 32'(FlushE), 0);
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Forwarding priority and R15 exclusion
        RegWriteM = 1; WA3M = 3; RA1E = 3; RegWriteW = 1; WA3W = 3;
        cycle("fwd_mem");
        chk("fwd_mem.const", 32'(ForwardAE), 32'h2);
        RegWriteM = 0;
        cycle("fwd_wb");
        chk("fwd_wb.const", 32'(ForwardAE), 32'h1);
        RA1E = 15; WA3W = 15;
        cycle("fwd_pc");
        chk("fwd_pc.const", 32'(ForwardAE), 32'h0);
        RegWriteM = 1; WA3M = 7; RA2E = 7; RegWriteW = 1; WA3W = 7;
        cycle("fwd_b_mem");
        zero_inputs();

        // Load-use stall
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; RA1D = 2;
        cycle("ldstall");
        chk("ldstall.cnt_before", 32'(obs_sc), 0);
        zero_inputs();
        cycle("ldstall_after");
        chk("ldstall.cnt_after", 32'(obs_sc), 1);

        // PC write: 3 stall cycles, 4 flush cycles
        n_sf = 0; n_fd = 0;
        PCSrcD = 1;
        cycle("pcw0");
        n_sf += obs_sf; n_fd += obs_fd;
        PCSrcD = 0;
        for (int i = 1; i < 7; i++) begin
            cycle($sformatf("pcw%0d", i));
            n_sf += obs_sf; n_fd += obs_fd;
        end
        chk("pcw.stallF_cycles", 32'(n_sf), 3);
        chk("pcw.flushD_cycles", 32'(n_fd), 4);

        // Branch squashes a Decode-stage PC write
        PCSrcD = 1; BranchTakenE = 1;
        cycle("br_squash");
        begin
            logic [15:0] fc0;
            fc0 = obs_fc;
            zero_inputs();
            cycle("br_squash_after");
            chk("br_squash.StallF", 32'(obs_sf), 0);
            chk("br_squash.FlushD", 32'(obs_fd), 0);
            chk("br_squash.flush_inc", 32'(obs_fc), 32'(fc0) + 1);
        end

        // clr_cnt beats increment; then saturation in the 3-bit instance
        MemtoRegE = 1; RegWriteE = 1; WA3E = 9; RA1D = 9;
        clr_cnt = 1;
        for (int i = 0; i < 3; i++) cycle($sformatf("clr_hold%0d", i));
        clr_cnt = 0;
        cycle("clr_release");
        chk("clr.stall_cnt", 32'(obs_sc), 0);
        for (int i = 0; i < 10; i++) cycle($sformatf("sat%0d", i));
        chk("sat.small_stall", 32'(s_stall_cnt), 7);
        chk("sat.big_stall", 32'(stall_cnt), 11);
        zero_inputs();

        // Asynchronous reset with a PC write in flight
        PCSrcD = 1;
        cycle("rst_pcw0");
        PCSrcD = 0;
        cycle("rst_pcw1");
        #1;
        chk("rst_async.pre_StallF", 32'(StallF), 1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_async.StallF", 32'(StallF), 0);
        chk("rst_async.FlushD", 32'(FlushD), 0);
        chk("rst_async.stall_cnt", 32'(stall_cnt), 0);
        chk("rst_async.flush_cnt", 32'(flush_cnt), 0);
        chk("rst_async.s_stall_cnt", 32'(s_stall_cnt), 0);
        @(negedge clk);
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4; RA1D = 4;
        cycle("rst_hold");
        zero_inputs();
        reset = 1'b1;
        cycle("rst_release");

        // Random traffic against the reference model
        for (int i = 0; i < 120; i++) begin
            RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
            RA1E = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            RA2E = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            WA3E = 4'($urandom_range(0, 3));
            WA3M = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            WA3W = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = 1'($urandom_range(0, 1));
            PCSrcD = ($urandom_range(0, 5) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            clr_cnt = ($urandom_range(0, 19) == 0);
            cycle($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the five-stage pipelined ARM datapath (Fetch/Decode/Execute/Memory/Writeback).
- Generates the Execute-stage operand forwarding selects, plus stall and flush controls for the inter-stage pipeline registers.
- Tracks in-flight PC writes (writes to R15) internally with a 3-deep shift register.
- Keeps saturating stall and flush event counters for bring-up and performance checks.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset; reset=0 asserts.
- RA1D  in  4  Decode source register 1.
- RA2D  in  4  Decode source register 2.
- RA1E  in  4  Execute source register 1.
- RA2E  in  4  Execute source register 2.
- WA3E  in  4  Execute destination register.
- WA3M  in  4  Memory destination register.
- WA3W  in  4  Writeback destination register.
- RegWriteE  in  1  Execute-stage register write enable.
- RegWriteM  in  1  Memory-stage register write enable.
- RegWriteW  in  1  Writeback-stage register write enable.
- MemtoRegE  in  1  Execute-stage instruction is a load.
- PCSrcD  in  1  Decode-stage instruction writes R15.
- BranchTakenE  in  1  Branch resolved taken in Execute.
- clr_cnt  in  1  synchronous clear of both counters.
- ForwardAE  out  2  SrcA select: 00 = regfile, 01 = resultW, 10 = ALUOutM.
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the F/D pipeline register.
- FlushD  out  1  clear the F/D pipeline register.
- FlushE  out  1  clear the D/E pipeline register.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of cycles with FlushE asserted.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM and WA3M==RA1E and RA1E!=4'hF.
  - Otherwise ForwardAE = 01 if RegWriteW and WA3W==RA1E and RA1E!=4'hF.
  - Otherwise ForwardAE = 00.
  - Memory stage has priority over Writeback when both match.
  - ForwardBE uses the same rules with RA2E.
  - R15 is never forwarded.
- Load-use detection: ldstall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- PC-write tracking state, three flops pcw_E, pcw_M, pcw_W, updated every rising edge:
  - pcw_E <= PCSrcD & ~FlushE.
  - pcw_M <= pcw_E.
  - pcw_W <= pcw_M.
  - The shift register is never stalled, because a stalled Decode slot is bubbled by FlushE.
- pcwr_pend = PCSrcD | pcw_E | pcw_M.
- Control outputs (combinational from inputs and state):
  - StallF = ldstall | pcwr_pend.
  - StallD = ldstall.
  - FlushD = pcwr_pend | pcw_W | BranchTakenE.
  - FlushE = ldstall | BranchTakenE.
- Simultaneous events:
  - ldstall together with BranchTakenE: FlushE=1 and StallD=1. The flushed Decode instruction is on the wrong path, so holding D is harmless.
  - BranchTakenE squashes a Decode-stage PCSrcD: pcw_E loads 0 because FlushE=1.
- Counters, updated at the rising edge:
  - stall_cnt increments when ldstall=1.
  - flush_cnt increments when FlushE=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - clr_cnt=1 zeroes both counters and takes priority over an increment in the same cycle.
- Reset:
  - reset=0 immediately clears pcw_E, pcw_M, pcw_W, stall_cnt and flush_cnt, without waiting for a clock edge.
  - Combinational outputs keep following the inputs with state=0. With all inputs 0: ForwardAE = ForwardBE = 00 and all stall/flush outputs are 0.
  - Reset asserted mid-sequence abandons any pending PC write.
- Latency: forwarding, stall and flush decisions take effect in the same cycle as their inputs. PC-write tracking spans 3 edges after PCSrcD is seen in Decode.

Decomposition:
- Shared package holds:
  - the forwarding-select typedef (FWD_RF=00, FWD_WB=01, FWD_MEM=10);
  - the constant REG_PC=4'hF.
- One sub-module, sat_counter (parameter W; ports clk, reset, clr, inc, count), instantiated twice.
- Forwarding, hazard equations and the pcw shift register stay in the top module.

Test Plan:
- RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RA1E=15 -> ForwardAE=00.
- MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1 for that cycle; stall_cnt goes 0->1 at the next edge.
- PCSrcD=1 for one cycle, then 0 -> StallF=1 for 3 cycles (D, E, M) and FlushD=1 for 4 cycles (D, E, M, W); then all 0.
- PCSrcD=1 together with BranchTakenE=1 -> pcw_E stays 0; StallF and FlushD drop one cycle later; flush_cnt +1.
- Hold ldstall and clr_cnt together -> stall_cnt stays 0. Preload stall_cnt to 16'hFFFF and hold ldstall -> stays at FFFF.
- Assert reset=0 asynchronously with pcw_M=1 and counters nonzero -> state and counters read 0 before the next clk edge; StallF follows the inputs only.
